regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning address bits (DEPTH = 2^N registers).
REQ-002 The block SHALL have parameter W, default 16, meaning data word width (legal 8..64).
REQ-003 The block SHALL have parameter NR, default 2, meaning number of read ports (legal 1..4).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port we, input, 1 bit: writeback enable.
REQ-007 The block SHALL have port addr_rd, input, N bits: writeback address.
REQ-008 The block SHALL have port data_in, input, W bits: writeback data.
REQ-009 The block SHALL have port addr_rs, input, NR x N bits (packed): read addresses.
REQ-010 The block SHALL have port rs, output, NR x W bits (packed): read data.
REQ-011 The block SHALL have port rs_busy, output, NR bits: scoreboard busy flag of each read address.
REQ-012 The block SHALL have port res_valid, input, 1 bit: reserve request.
REQ-013 The block SHALL have port res_addr, input, N bits: register to reserve.
REQ-014 The block SHALL have port res_ready, output, 1 bit: reserve accepted this cycle.
REQ-015 The block SHALL have port clear_req, input, 1 bit: soft-clear request (single-cycle pulse).
REQ-016 The block SHALL have port clear_busy, output, 1 bit: clear sequence in progress.
REQ-017 The block SHALL have port busy_count, output, N+1 bits: number of busy registers.

Function
REQ-018 Register 0 SHALL read 0 with rs_busy 0; writes and reserves to address 0 SHALL have no effect, and res_ready SHALL be 1 for address 0 outside CLEAR.
REQ-019 Reads SHALL be combinational, zero latency, all NR ports independent: rs[i] = reg[addr_rs[i]], rs_busy[i] = busy[addr_rs[i]].
REQ-020 When we=1 and addr_rd≠0 in IDLE, reg[addr_rd] SHALL take data_in at the rising edge and busy[addr_rd] SHALL clear.
REQ-021 res_ready SHALL equal (state==IDLE) and not busy[res_addr]; on res_valid and res_ready, busy[res_addr] SHALL be set at the next edge.
REQ-022 When writeback and an accepted reserve target the same address in one cycle, the data SHALL be written and busy SHALL end set (reserve wins).
REQ-023 busy_count SHALL be registered, updated in the same edge as busy, range 0..DEPTH-1.
REQ-024 The FSM SHALL have two states: IDLE and CLEAR; CLEAR walks a counter from 1 to DEPTH-1, writing 0 to one register per cycle, then returns to IDLE (DEPTH-1 cycles total).
REQ-025 In CLEAR: clear_busy=1, res_ready=0, we ignored, all rs forced to 0, all rs_busy forced to 0.
REQ-026 clear_req in IDLE SHALL enter CLEAR at the next edge and zero all busy bits and busy_count; clear_req during CLEAR SHALL restart the counter at 1.

Reset
REQ-027 rst SHALL asynchronously set state=CLEAR, counter=1, busy bits=0, busy_count=0; storage SHALL NOT be reset directly and SHALL be zeroed by the CLEAR walk.
REQ-028 rst asserted mid-CLEAR or mid-operation SHALL restart the full clear sequence after release.

Configuration
REQ-029 With REGFILE_BYPASS_EN defined, a read port whose addr_rs equals addr_rd (≠0) while we=1 in IDLE SHALL return data_in and rs_busy=0 in the same cycle.
REQ-030 Without REGFILE_BYPASS_EN, such a read SHALL return the old register value and the current busy flag until the edge.

Structure
REQ-031 A package regfile_pkg SHALL hold the FSM state enum (IDLE, CLEAR) and default parameter constants.
REQ-032 A sub-module regfile_scoreboard_busy SHALL hold the busy vector, busy_count and the reserve/writeback arbitration.

Verification
REQ-033 Reset release -> clear_busy=1 for exactly 15 cycles (N=4), then all rs=0, busy_count=0, res_ready=1.
REQ-034 Reserve r5 -> rs_busy=1 on a port reading 5, busy_count=1, second reserve of r5 sees res_ready=0; writeback r5=0xA5A5 -> rs=0xA5A5, rs_busy=0, busy_count=0.
REQ-035 Same-cycle reserve r7 and writeback r7=0x1234 -> rs=0x1234, rs_busy=1.
REQ-036 Write 0xFFFF and reserve to r0 -> rs=0, rs_busy=0, busy_count unchanged.
REQ-037 Bypass: we=1, addr_rd=3, data_in=0x5A5A, addr_rs[0]=3 -> rs[0]=0x5A5A before the edge with REGFILE_BYPASS_EN, old value without.
REQ-038 clear_req after 512 random writes/reserves (fixed seed, scoreboarded) -> CLEAR entered, busy_count=0, all registers read 0 after 15 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared state encoding and default sizing for the scoreboarded register file
package regfile_pkg;

  localparam int DEFAULT_N  = 4;
  localparam int DEFAULT_W  = 16;
  localparam int DEFAULT_NR = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_scoreboard_busy.sv
// rtl/regfile_scoreboard_busy.sv - per-register busy bits, busy population count, reserve/writeback arbitration
module regfile_scoreboard_busy
  import regfile_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               wb_en,
  input  logic [N-1:0]       wb_addr,
  input  logic               res_en,
  input  logic [N-1:0]       res_addr,
  output logic [(1<<N)-1:0]  busy,
  output logic [N:0]         busy_count
);

  localparam int DEPTH = 1 << N;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [N:0]       busy_count_q, busy_count_d;

  // Writeback releases, reserve sets afterwards so a same-cycle reserve wins; r0 is never busy
  always_comb begin
    busy_d       = busy_q;
    busy_count_d = '0;
    if (clear) begin
      busy_d = '0;
    end else begin
      if (wb_en)  busy_d[wb_addr]  = 1'b0;
      if (res_en) busy_d[res_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_count_d = busy_count_d + (N+1)'(busy_d[i]);
    end
  end

  // Busy bits and their count advance on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy       = busy_q;
  assign busy_count = busy_count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - multi-port register file with reservation scoreboard and walking clear; REGFILE_BYPASS_EN adds write-to-read bypass
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int W  = DEFAULT_W,
  parameter int NR = DEFAULT_NR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [N-1:0]    addr_rd,
  input  logic [W-1:0]    data_in,
  input  logic [NR*N-1:0] addr_rs,
  output logic [NR*W-1:0] rs,
  output logic [NR-1:0]   rs_busy,
  input  logic            res_valid,
  input  logic [N-1:0]    res_addr,
  output logic            res_ready,
  input  logic            clear_req,
  output logic            clear_busy,
  output logic [N:0]      busy_count
);

  localparam int DEPTH = 1 << N;
  localparam logic [N-1:0] LAST_ADDR = {N{1'b1}};
  localparam logic [N-1:0] FIRST_ADDR = N'(1);

  state_e         state_q, state_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic           idle;
  logic           wb_en;
  logic           res_en;
  logic [DEPTH-1:0] busy;
  logic           mem_we;
  logic [N-1:0]   mem_waddr;
  logic [W-1:0]   mem_wdata;
  logic [N-1:0]   rd_addr [NR];

  assign idle       = (state_q == IDLE);
  assign wb_en      = idle && we && (addr_rd != '0);
  assign res_ready  = idle && !busy[res_addr];
  assign res_en     = res_valid && res_ready && (res_addr != '0);
  assign clear_busy = !idle;

  regfile_scoreboard_busy #(.N(N)) u_busy (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_req),
    .wb_en      (wb_en),
    .wb_addr    (addr_rd),
    .res_en     (res_en),
    .res_addr   (res_addr),
    .busy       (busy),
    .busy_count (busy_count)
  );

  // Next state: clear_req (re)starts the walk at r1; the walk ends after r(DEPTH-1)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = FIRST_ADDR;
        end
      end
      CLEAR: begin
        if (clear_req) begin
          cnt_d = FIRST_ADDR;
        end else if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + N'(1);
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = FIRST_ADDR;
      end
    endcase
  end

  // Control state; reset lands in CLEAR so storage gets zeroed by the walk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= FIRST_ADDR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single storage write port: the clear walker owns it outside IDLE
  always_comb begin
    mem_we    = idle ? wb_en   : 1'b1;
    mem_waddr = idle ? addr_rd : cnt_q;
    mem_wdata = idle ? data_in : '0;
  end

  // Storage array, deliberately without reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Independent combinational read ports; r0 hardwired to zero, everything masked during CLEAR
  always_comb begin
    rs      = '0;
    rs_busy = '0;
    for (int i = 0; i < NR; i++) begin
      rd_addr[i] = addr_rs[i*N +: N];
      if (rd_addr[i] != '0) begin
        rs[i*W +: W] = mem_q[rd_addr[i]];
        rs_busy[i]   = busy[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
        if (wb_en && (rd_addr[i] == addr_rd)) begin
          rs[i*W +: W] = data_in;
          rs_busy[i]   = 1'b0;
        end
`endif
      end
      if (!idle) begin
        rs[i*W +: W] = '0;
        rs_busy[i]   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed and scoreboarded checks of regfile_scoreboard (N=4, W=16, NR=2)
module tb_regfile_scoreboard;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            we;
  logic [N-1:0]    addr_rd;
  logic [W-1:0]    data_in;
  logic [NR*N-1:0] addr_rs;
  logic [NR*W-1:0] rs;
  logic [NR-1:0]   rs_busy;
  logic            res_valid;
  logic [N-1:0]    res_addr;
  logic            res_ready;
  logic            clear_req;
  logic            clear_busy;
  logic [N:0]      busy_count;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]  mem_m [16];
  logic [15:0]   busy_m;
  logic [31:0]   seed;

  regfile_scoreboard #(.N(N), .W(W), .NR(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .addr_rd    (addr_rd),
    .data_in    (data_in),
    .addr_rs    (addr_rs),
    .rs         (rs),
    .rs_busy    (rs_busy),
    .res_valid  (res_valid),
    .res_addr   (res_addr),
    .res_ready  (res_ready),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .busy_count (busy_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [N-1:0] a0, input logic [N-1:0] a1);
    addr_rs = {a1, a0};
  endtask

  task automatic next_rnd(output logic [31:0] r);
    seed = seed ^ (seed << 13);
    seed = seed ^ (seed >> 17);
    seed = seed ^ (seed << 5);
    r = seed;
  endtask

  // Counts edges until clear_busy drops; optionally re-pulses clear_req or tries a write mid-walk
  task automatic wait_idle(output int n, input int restart_at, input int wr_at);
    n = 0;
    while (clear_busy && n < 100) begin
      if (n == restart_at) clear_req = 1'b1;
      if (n == wr_at) begin
        we = 1'b1; addr_rd = 4'd2; data_in = 16'hBEEF;
      end
      tick;
      clear_req = 1'b0;
      we = 1'b0;
      n++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      set_rd(4'(a), 4'(15 - a));
      #1;
      check({tag, "_rs0"}, rs[15:0], 16'h0);
      check({tag, "_rs1"}, rs[31:16], 16'h0);
      check({tag, "_bsy"}, rs_busy, 2'b00);
    end
  endtask

  initial begin
    int n;
    logic [31:0] r1, r2;
    logic [W-1:0] e_rd;
    logic e_bz;
    logic acc;
    logic [N-1:0] pa;

    rst = 1'b1; we = 1'b0; addr_rd = '0; data_in = '0; addr_rs = '0;
    res_valid = 1'b0; res_addr = '0; clear_req = 1'b0;
    seed = 32'h1BAD_5EED;
    #1;
    check("rst_clear_busy", clear_busy, 1'b1);
    check("rst_busy_count", busy_count, 5'd0);
    check("rst_res_ready", res_ready, 1'b0);
    repeat (3) tick;
    rst = 1'b0;
    wait_idle(n, -1, -1);
    check("rst_clear_len", n, 15);
    check_all_zero("post_rst");
    res_addr = 4'd5;
    #1;
    check("post_rst_cnt", busy_count, 5'd0);
    check("post_rst_ready", res_ready, 1'b1);

    // reserve r5, second reserve refused, writeback releases
    set_rd(4'd0, 4'd5);
    res_valid = 1'b1; res_addr = 4'd5;
    #1 check("r5_ready", res_ready, 1'b1);
    tick;
    res_valid = 1'b0;
    check("r5_busy", rs_busy[1], 1'b1);
    check("r5_cnt", busy_count, 5'd1);
    res_valid = 1'b1;
    #1 check("r5_ready2", res_ready, 1'b0);
    res_valid = 1'b0;
    we = 1'b1; addr_rd = 4'd5; data_in = 16'hA5A5;
    tick;
    we = 1'b0;
    check("r5_data", rs[31:16], 16'hA5A5);
    check("r5_release", rs_busy[1], 1'b0);
    check("r5_cnt0", busy_count, 5'd0);

    // same-cycle reserve and writeback of r7: data written, reserve wins
    set_rd(4'd0, 4'd7);
    we = 1'b1; addr_rd = 4'd7; data_in = 16'h1234;
    res_valid = 1'b1; res_addr = 4'd7;
    tick;
    we = 1'b0; res_valid = 1'b0;
    check("r7_data", rs[31:16], 16'h1234);
    check("r7_busy", rs_busy[1], 1'b1);
    check("r7_cnt", busy_count, 5'd1);

    // r0 ignores write and reserve
    set_rd(4'd0, 4'd0);
    we = 1'b1; addr_rd = 4'd0; data_in = 16'hFFFF;
    res_valid = 1'b1; res_addr = 4'd0;
    #1 check("r0_ready", res_ready, 1'b1);
    tick;
    we = 1'b0; res_valid = 1'b0;
    check("r0_data", rs[15:0], 16'h0);
    check("r0_busy", rs_busy[0], 1'b0);
    check("r0_cnt", busy_count, 5'd1);

    // write-to-read bypass on r3 (reserved first), port 1 reads r4
    we = 1'b1; addr_rd = 4'd3; data_in = 16'h1111;
    tick;
    we = 1'b0;
    res_valid = 1'b1; res_addr = 4'd3;
    tick;
    res_valid = 1'b0;
    set_rd(4'd3, 4'd4);
    we = 1'b1; addr_rd = 4'd3; data_in = 16'h5A5A;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_rs0", rs[15:0], 16'h5A5A);
    check("byp_bsy0", rs_busy[0], 1'b0);
`else
    check("byp_rs0", rs[15:0], 16'h1111);
    check("byp_bsy0", rs_busy[0], 1'b1);
`endif
    check("byp_rs1", rs[31:16], 16'h0);
    tick;
    we = 1'b0;
    check("byp_after", rs[15:0], 16'h5A5A);
    check("byp_after_bsy", rs_busy[0], 1'b0);
    check("byp_cnt", busy_count, 5'd1);

    // clear entry masks reads, then restart mid-walk
    set_rd(4'd7, 4'd3);
    res_addr = 4'd0;
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    check("clr_state", clear_busy, 1'b1);
    check("clr_cnt", busy_count, 5'd0);
    check("clr_rs0", rs[15:0], 16'h0);
    check("clr_rs1", rs[31:16], 16'h0);
    check("clr_bsy", rs_busy, 2'b00);
    check("clr_ready", res_ready, 1'b0);
    wait_idle(n, 5, -1);
    check("clr_restart_len", n, 21);
    check_all_zero("clr1");

    // scoreboarded random traffic
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    busy_m = '0;
    for (int k = 0; k < 512; k++) begin
      next_rnd(r1);
      next_rnd(r2);
      we = r1[0]; addr_rd = r1[7:4]; data_in = r1[31:16];
      res_valid = r1[1]; res_addr = r2[3:0];
      set_rd(r2[7:4], r2[11:8]);
      #1;
      for (int p = 0; p < NR; p++) begin
        pa = addr_rs[p*N +: N];
        e_rd = mem_m[pa];
        e_bz = busy_m[pa];
`ifdef REGFILE_BYPASS_EN
        if (we && pa != 0 && pa == addr_rd) begin
          e_rd = data_in;
          e_bz = 1'b0;
        end
`endif
        check($sformatf("rnd%0d_rs%0d", k, p), rs[p*W +: W], e_rd);
        check($sformatf("rnd%0d_bsy%0d", k, p), rs_busy[p], e_bz);
      end
      check($sformatf("rnd%0d_ready", k), res_ready, !busy_m[res_addr]);
      acc = res_valid && !busy_m[res_addr];
      tick;
      if (we && addr_rd != 0) begin
        mem_m[addr_rd] = data_in;
        busy_m[addr_rd] = 1'b0;
      end
      if (acc && res_addr != 0) busy_m[res_addr] = 1'b1;
      check($sformatf("rnd%0d_cnt", k), busy_count, 5'($countones(busy_m)));
    end
    we = 1'b0; res_valid = 1'b0;

    // clear after random traffic; a write attempt mid-walk must be ignored
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    check("clr2_state", clear_busy, 1'b1);
    check("clr2_cnt", busy_count, 5'd0);
    wait_idle(n, -1, 10);
    check("clr2_len", n, 15);
    check_all_zero("clr2");
    res_addr = 4'd9;
    #1;
    check("clr2_cnt_end", busy_count, 5'd0);
    check("clr2_ready", res_ready, 1'b1);

    // asynchronous reset mid-operation restarts the full clear
    res_valid = 1'b1; res_addr = 4'd6;
    tick;
    res_valid = 1'b0;
    check("ar_cnt_before", busy_count, 5'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_clear_busy", clear_busy, 1'b1);
    check("ar_cnt", busy_count, 5'd0);
    tick;
    rst = 1'b0;
    wait_idle(n, -1, -1);
    check("ar_clear_len", n, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
